// File: rtl/mem_copy_engine_pkg.sv
// Shared constants and FSM encoding for the memory block-copy engine.
`timescale 1ns/1ps
package mem_copy_engine_pkg;

   localparam int ADDR_W         = 16;
   localparam int DATA_W         = 16;
   localparam int ROM_PAGE_WORDS = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus-master block copier: one READ then one WRITE cycle per word, all outputs registered.
// Done pulses 2N+1 cycles after an accepted start (1 cycle for len=0); abort finishes the current bus cycle.
`timescale 1ns/1ps
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int AW        = ADDR_W,
   parameter int DW        = DATA_W,
   parameter int ROM_WORDS = ROM_PAGE_WORDS
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          rom_err,
   output logic [AW-1:0] remaining,
   output logic [AW-1:0] mem_addr,
   output logic          mem_en,
   output logic          mem_load_n,
   output logic [DW-1:0] bus_out,
   output logic          bus_oe,
   input  logic [DW-1:0] bus_in
);

   localparam logic [AW-1:0] ROM_LIMIT = AW'(ROM_WORDS);

   state_t        state, state_nx;
   logic [AW-1:0] cur_src, cur_dst;
   logic [AW-1:0] src_nx, dst_nx, rem_nx, addr_nx;
   logic [DW-1:0] data, data_nx;
   logic          err_nx, busy_nx, done_nx, en_nx, load_n_nx, oe_nx;

   assign bus_out = data;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cur_src    <= '0;
         cur_dst    <= '0;
         remaining  <= '0;
         data       <= '0;
         rom_err    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_addr   <= '0;
         mem_en     <= 1'b0;
         mem_load_n <= 1'b1;
         bus_oe     <= 1'b0;
      end else begin
         state      <= state_nx;
         cur_src    <= src_nx;
         cur_dst    <= dst_nx;
         remaining  <= rem_nx;
         data       <= data_nx;
         rom_err    <= err_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         mem_addr   <= addr_nx;
         mem_en     <= en_nx;
         mem_load_n <= load_n_nx;
         bus_oe     <= oe_nx;
      end
   end

   // Outputs are derived from the next state so they line up with the state they belong to.
   always_comb begin
      state_nx  = state;
      src_nx    = cur_src;
      dst_nx    = cur_dst;
      rem_nx    = remaining;
      data_nx   = data;
      err_nx    = rom_err;
      busy_nx   = 1'b0;
      done_nx   = 1'b0;
      addr_nx   = mem_addr;
      en_nx     = 1'b0;
      load_n_nx = 1'b1;
      oe_nx     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               src_nx   = src;
               dst_nx   = dst;
               rem_nx   = len;
               err_nx   = 1'b0;
               state_nx = (len != '0) ? ST_READ : ST_DONE;
            end
         end
         ST_READ: begin
            data_nx  = bus_in;
            state_nx = abort ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            src_nx   = cur_src + 1'b1;
            dst_nx   = cur_dst + 1'b1;
            rem_nx   = remaining - 1'b1;
            state_nx = (abort || remaining == {{(AW-1){1'b0}}, 1'b1}) ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      busy_nx = (state_nx != ST_IDLE);
      done_nx = (state_nx == ST_DONE);

      if (state_nx == ST_READ) begin
         addr_nx = src_nx;
         en_nx   = 1'b1;
      end else if (state_nx == ST_WRITE) begin
         addr_nx = dst_nx;
         oe_nx   = 1'b1;
         // The ROM page is skipped silently but flagged; the word still counts as copied.
         if (dst_nx >= ROM_LIMIT) begin
            load_n_nx = 1'b0;
         end else begin
            err_nx = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a behavioural 64K-word memory on the bus.
`timescale 1ns/1ps
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src = '0, dst = '0, len = '0;
   logic        abort = 1'b0;
   logic        busy, done, rom_err, mem_en, mem_load_n, bus_oe;
   logic [15:0] remaining, mem_addr, bus_out, bus_in;

   mem_copy_engine dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src(src), .dst(dst), .len(len),
      .abort(abort), .busy(busy), .done(done), .rom_err(rom_err), .remaining(remaining),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_load_n(mem_load_n), .bus_out(bus_out),
      .bus_oe(bus_oe), .bus_in(bus_in)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = '0, pl_dat = '0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_dat;
      else if (!mem_load_n) mem[mem_addr] <= bus_out;
   end

   assign bus_in = mem_en ? mem[mem_addr] : (bus_oe ? bus_out : 16'h0000);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [15:0] addr; logic [15:0] dat; } wr_t;
   typedef struct { int at; logic [15:0] rem; logic err; } dn_t;

   wr_t         wr_q[$];
   logic [15:0] rd_q[$];
   dn_t         dn_q[$];

   int n_tot = 0, n_pass = 0, viol = 0, busy_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_tot++;
      $display("FAIL %s: got %0h, expected no event", name, act);
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      src = s; dst = d; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_done(input int at, input logic [15:0] rem, input logic err);
      dn_t e;
      e.at = at; e.rem = rem; e.err = err;
      dn_q.push_back(e);
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a; e.dat = d;
      wr_q.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && dn_q.size() == 0) break;
      end
      chk({name, " busy_at_end"}, busy, 1'b0);
      chk({name, " pending_done"}, dn_q.size(), 0);
      chk({name, " pending_writes"}, wr_q.size(), 0);
      chk({name, " pending_reads"}, rd_q.size(), 0);
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, " busy"}, busy, 1'b0);
      chk({name, " done"}, done, 1'b0);
      chk({name, " rom_err"}, rom_err, 1'b0);
      chk({name, " remaining"}, remaining, 16'h0);
      chk({name, " mem_addr"}, mem_addr, 16'h0);
      chk({name, " mem_en"}, mem_en, 1'b0);
      chk({name, " mem_load_n"}, mem_load_n, 1'b1);
      chk({name, " bus_out"}, bus_out, 16'h0);
      chk({name, " bus_oe"}, bus_oe, 1'b0);
   endtask

   int b0;

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mem_en && bus_oe) viol++;
            if (!mem_load_n && !bus_oe) viol++;
            if (mem_en) begin
               if (rd_q.size() == 0) unexpected("read_addr", mem_addr);
               else chk("read_addr", mem_addr, rd_q.pop_front());
            end
            if (!mem_load_n) begin
               if (wr_q.size() == 0) unexpected("write", {mem_addr, bus_out});
               else begin
                  wr_t w;
                  w = wr_q.pop_front();
                  chk("write_addr", mem_addr, w.addr);
                  chk("write_data", bus_out, w.dat);
               end
            end
            if (done) begin
               if (dn_q.size() == 0) unexpected("done", cyc);
               else begin
                  dn_t e;
                  e = dn_q.pop_front();
                  chk("done_cycle", cyc, e.at);
                  chk("done_remaining", remaining, e.rem);
                  chk("done_rom_err", rom_err, e.err);
               end
            end
         end
      join_none

      // Memory image under reset: ROM words plus RAM sources.
      @(negedge clk);
      preload(16'h0000, 16'h0101);
      preload(16'h0001, 16'h0300);
      preload(16'h0002, 16'h0102);
      preload(16'h00FE, 16'hA0FE);
      preload(16'h00FF, 16'hA0FF);
      preload(16'd600, 16'd11);
      preload(16'd601, 16'd22);
      preload(16'd602, 16'd33);
      preload(16'd603, 16'd44);
      preload(16'hFFFE, 16'h1111);
      preload(16'hFFFF, 16'h2222);
      for (int i = 0; i < 5; i++) preload(16'h2000 + 16'(i), 16'hC000 + 16'(i));
      preload(16'h3002, 16'h0000);
      check_reset_vals("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // ROM to RAM copy
      rd_q.push_back(16'd0); rd_q.push_back(16'd1); rd_q.push_back(16'd2);
      push_wr(16'd500, 16'h0101); push_wr(16'd501, 16'h0300); push_wr(16'd502, 16'h0102);
      push_done(cyc + 7, 16'd0, 1'b0);
      b0 = busy_cnt;
      go(16'd0, 16'd500, 16'd3);
      chk("t1 remaining_after_start", remaining, 16'd3);
      wait_idle("t1");
      chk("t1 busy_cycles", busy_cnt - b0, 7);
      chk("t1 ram500", mem[500], 16'h0101);
      chk("t1 ram501", mem[501], 16'h0300);
      chk("t1 ram502", mem[502], 16'h0102);

      // Zero-length copy
      push_done(cyc + 1, 16'd0, 1'b0);
      b0 = busy_cnt;
      go(16'd5, 16'd700, 16'd0);
      wait_idle("t2");
      chk("t2 busy_cycles", busy_cnt - b0, 1);

      // Destination straddles the ROM page boundary
      rd_q.push_back(16'd600); rd_q.push_back(16'd601);
      rd_q.push_back(16'd602); rd_q.push_back(16'd603);
      push_wr(16'd256, 16'd33); push_wr(16'd257, 16'd44);
      push_done(cyc + 9, 16'd0, 1'b1);
      go(16'd600, 16'd254, 16'd4);
      wait_idle("t3");
      chk("t3 rom254", mem[254], 16'hA0FE);
      chk("t3 rom255", mem[255], 16'hA0FF);
      chk("t3 ram256", mem[256], 16'd33);
      chk("t3 ram257", mem[257], 16'd44);
      chk("t3 rom_err_sticky", rom_err, 1'b1);

      // Overlapping copy replicates the first word
      preload(16'd600, 16'd8907);
      for (int i = 0; i < 4; i++) begin
         rd_q.push_back(16'd600 + 16'(i));
         push_wr(16'd601 + 16'(i), 16'd8907);
      end
      push_done(cyc + 9, 16'd0, 1'b0);
      go(16'd600, 16'd601, 16'd4);
      chk("t4 rom_err_cleared", rom_err, 1'b0);
      wait_idle("t4");
      for (int i = 0; i < 5; i++) chk("t4 fill", mem[600 + i], 16'd8907);

      // Source address wraps
      rd_q.push_back(16'hFFFE); rd_q.push_back(16'hFFFF); rd_q.push_back(16'h0000);
      push_wr(16'h1000, 16'h1111); push_wr(16'h1001, 16'h2222); push_wr(16'h1002, 16'h0101);
      push_done(cyc + 7, 16'd0, 1'b0);
      go(16'hFFFE, 16'h1000, 16'd3);
      wait_idle("t5");
      chk("t5 ram1002", mem[16'h1002], 16'h0101);

      // Abort during the second write of five
      rd_q.push_back(16'h2000); rd_q.push_back(16'h2001);
      push_wr(16'h3000, 16'hC000); push_wr(16'h3001, 16'hC001);
      push_done(cyc + 5, 16'd3, 1'b0);
      go(16'h2000, 16'h3000, 16'd5);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle("t6");
      chk("t6 remaining_held", remaining, 16'd3);
      chk("t6 ram3002_untouched", mem[16'h3002], 16'h0000);

      // Start ignored while busy, then reset mid-READ
      rd_q.push_back(16'h2000); rd_q.push_back(16'h2001);
      push_wr(16'h4000, 16'hC000);
      go(16'h2000, 16'h4000, 16'd4);
      @(negedge clk);
      src = 16'h5000; dst = 16'h6000; len = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_vals("mid_reset");
      reset_n = 1'b1;
      chk("t7 pending_writes", wr_q.size(), 0);
      chk("t7 pending_reads", rd_q.size(), 0);
      chk("t7 ram4000", mem[16'h4000], 16'hC000);
      repeat (3) @(negedge clk);
      chk("t7 idle_after_reset", busy, 1'b0);

      chk("bus_invariant_violations", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus-master initiator for the SCAMP Memory block. It copies a block of 16-bit words from a source address range to a destination address range.
- It drives the Memory's address, en (read-out-to-bus) and active-low load (write) controls, and the shared data bus.
- It sits beside the CPU on the memory bus; the top level grants it the bus while busy.

Parameters:
- AW, 16, address width; addresses wrap modulo 2^AW.
- DW, 16, data/bus width.
- ROM_WORDS, 256, size of the read-only first page; destination addresses below this are never written.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  begin copy; honoured only in IDLE
- src  input  AW  first source address, latched on accepted start
- dst  input  AW  first destination address, latched on accepted start
- len  input  AW  word count, latched on accepted start; 0 is legal
- abort  input  1  terminate an in-progress copy
- busy  output  1  high from the cycle after an accepted start through DONE
- done  output  1  one-cycle pulse at completion or abort
- rom_err  output  1  sticky; set if any destination write targeted the ROM page; cleared on accepted start
- remaining  output  AW  words not yet written
- mem_addr  output  AW  Memory address
- mem_en  output  1  Memory drives bus with mem[mem_addr]
- mem_load_n  output  1  active-low; Memory writes bus to mem[mem_addr] on rising edge
- bus_out  output  DW  write data
- bus_oe  output  1  engine drives the bus; the top level builds the tristate
- bus_in  input  DW  current bus value

Behaviour:
- Clock and reset: single clock domain, clk. reset_n is synchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, rom_err=0, remaining=0, mem_addr=0, mem_en=0, mem_load_n=1, bus_out=0, bus_oe=0.
- Reset mid-copy: all outputs take their reset values at the next edge. A write in the same cycle still completes in the Memory.
- Invariant: mem_en and bus_oe are never both 1. mem_load_n=0 only while bus_oe=1.
- States: IDLE, READ, WRITE, DONE. Outputs are registered.
- IDLE:
  - start=1 latches src/dst/len and clears rom_err.
  - Next state is READ if len!=0, otherwise DONE.
  - start while not IDLE is ignored.
- READ (1 cycle):
  - Drives mem_addr=cur_src, mem_en=1, mem_load_n=1, bus_oe=0.
  - Memory read is combinational, so bus_in is captured into the data register at the closing edge.
  - Then goes to WRITE.
- WRITE (1 cycle):
  - Drives mem_addr=cur_dst, bus_out=data, bus_oe=1, mem_en=0.
  - mem_load_n=0 if cur_dst>=ROM_WORDS. Otherwise mem_load_n=1 and rom_err is set; the address is skipped but still counted.
  - At the closing edge: cur_src+=1, cur_dst+=1 (both wrap 0xFFFF->0x0000), remaining-=1.
  - Next state is DONE if remaining becomes 0, otherwise READ.
- DONE (1 cycle): done=1, busy=1, bus released; then IDLE.
- Throughput: 2 cycles per word. For len=N>0, done is high in cycle 2N+1 after the start edge. For len=0, done is high in cycle 1.
- Copy order is strictly ascending and word-by-word. With overlap where dst>src, already-copied words are re-read, giving a deliberate fill/replicate.
- abort=1 in READ or WRITE: the current cycle's bus action completes, then the next state is DONE. remaining holds the unwritten count. abort in IDLE/DONE is ignored.
- abort and start together in IDLE: start wins.

Decomposition:
- Shared package: state encoding constants (IDLE/READ/WRITE/DONE), ROM_WORDS, bus width constants.
- No sub-module; a single FSM plus a datapath of registers (cur_src, cur_dst, remaining, data).

Test Plan:
- Copy src=0, dst=500, len=3 from ROM -> RAM[500..502]=0x0101,0x0300,0x0102; done in cycle 7; rom_err=0; mem_en/bus_oe never overlap.
- len=0 with start -> done in cycle 1, busy high for exactly 1 cycle, mem_load_n stays 1 throughout.
- dst=254, len=4, src=600 (RAM preloaded 11,22,33,44) -> RAM[256]=33, RAM[257]=44; ROM[254..255] unchanged; rom_err=1; cleared by the next start.
- Overlap fill: RAM[600]=8907, src=600, dst=601, len=4 -> RAM[600..604] all 8907.
- Wrap: src=0xFFFE, dst=0x1000, len=3 -> reads addresses 0xFFFE, 0xFFFF, 0x0000 in order into 0x1000..0x1002.
- Control: abort asserted in the 2nd WRITE of len=5 -> two words written, done next cycle, remaining=3. reset_n=0 mid-READ -> all outputs at reset values after one edge, and start ignored while busy.
